// File: rtl/lab2_encoder_event_fifo.sv
`default_nettype none
// ============================================================================
// Module      : lab2_encoder_event_fifo
// Description : Detects new {v, aout} events from a 4-bit priority encoder
//               and queues their 2-bit codes in a first-word-fall-through
//               FIFO. Also keeps a saturating accepted-event counter and a
//               sticky overflow flag.
// Revision    : 1.0 - initial release
// ============================================================================
module lab2_encoder_event_fifo #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [1:0]                 aout,
  input  logic                       v,
  input  logic                       pop,
  output logic [1:0]                 out_code,
  output logic                       out_valid,
  output logic [$clog2(DEPTH):0]     level,
  output logic                       full,
  output logic                       empty,
  output logic                       overflow,
  output logic [CNT_W-1:0]           ev_cnt
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
  localparam logic [LVL_W-1:0] LVL_ONE  = LVL_W'(1);
  localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(DEPTH);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

  logic             prev_v;
  logic [1:0]       prev_aout;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [LVL_W-1:0] level_q;
  logic             overflow_q;
  logic [CNT_W-1:0] ev_cnt_q;
  logic [1:0]       mem [DEPTH];

  logic             event_det;
  logic             do_pop;
  logic             do_push;
  logic             is_full;
  logic             is_empty;

  // Event detection and push/pop qualification. A push into a full FIFO is
  // still accepted when a pop frees the head slot in the same cycle.
  always_comb begin
    is_full   = (level_q == LVL_FULL);
    is_empty  = (level_q == '0);
    event_det = v && (!prev_v || (aout != prev_aout));
    do_pop    = pop && !is_empty;
    do_push   = event_det && (!is_full || do_pop);
  end

  // History registers, pointers, level, overflow flag and event counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      prev_v     <= 1'b0;
      prev_aout  <= 2'd0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      level_q    <= '0;
      overflow_q <= 1'b0;
      ev_cnt_q   <= '0;
    end else begin
      prev_v    <= v;
      prev_aout <= aout;
      if (do_push) begin
        wr_ptr <= wr_ptr + PTR_ONE;
        if (ev_cnt_q != CNT_MAX) begin
          ev_cnt_q <= ev_cnt_q + CNT_ONE;
        end
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
      if (event_det && !do_push) begin
        overflow_q <= 1'b1;
      end
      if (do_push && !do_pop) begin
        level_q <= level_q + LVL_ONE;
      end else if (do_pop && !do_push) begin
        level_q <= level_q - LVL_ONE;
      end
    end
  end

  // Storage array; contents are only meaningful below level, so no reset.
  always_ff @(posedge clk) begin
    if (!rst && do_push) begin
      mem[wr_ptr] <= aout;
    end
  end

  // Outputs come from registered state only.
  always_comb begin
    out_code  = is_empty ? 2'd0 : mem[rd_ptr];
    out_valid = !is_empty;
    level     = level_q;
    full      = is_full;
    empty     = is_empty;
    overflow  = overflow_q;
    ev_cnt    = ev_cnt_q;
  end

endmodule
`default_nettype wire

// File: tb/tb_lab2_encoder_event_fifo.sv
`default_nettype none
// ============================================================================
// Module      : tb_lab2_encoder_event_fifo
// Description : Directed self-checking bench for lab2_encoder_event_fifo.
//               A second instance with CNT_W=2 shares the stimulus and is
//               used for the counter saturation scenario.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_lab2_encoder_event_fifo;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] aout = 2'd0;
  logic       v = 1'b0;
  logic       pop = 1'b0;

  logic [1:0] out_code;
  logic       out_valid;
  logic [2:0] level;
  logic       full;
  logic       empty;
  logic       overflow;
  logic [7:0] ev_cnt;

  logic [1:0] s_out_code;
  logic       s_out_valid;
  logic [2:0] s_level;
  logic       s_full;
  logic       s_empty;
  logic       s_overflow;
  logic [1:0] s_ev_cnt;

  int tests_run = 0;
  int tests_failed = 0;

  lab2_encoder_event_fifo #(.DEPTH(4), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .aout(aout), .v(v), .pop(pop),
    .out_code(out_code), .out_valid(out_valid), .level(level),
    .full(full), .empty(empty), .overflow(overflow), .ev_cnt(ev_cnt)
  );

  lab2_encoder_event_fifo #(.DEPTH(4), .CNT_W(2)) dut_small (
    .clk(clk), .rst(rst), .aout(aout), .v(v), .pop(pop),
    .out_code(s_out_code), .out_valid(s_out_valid), .level(s_level),
    .full(s_full), .empty(s_empty), .overflow(s_overflow), .ev_cnt(s_ev_cnt)
  );

  always #5 clk = ~clk;

  // Advance one rising edge and settle just past it.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; v = 1'b0; aout = 2'd0; pop = 1'b0;
    cyc();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; v = 1'b0; aout = 2'd3; pop = 1'b0;
    cyc();
    tests_run++; if (empty !== 1'b1) begin tests_failed++; $display("FAIL rst_empty got %0d want 1", empty); end
    tests_run++; if (level !== 3'd0) begin tests_failed++; $display("FAIL rst_level got %0d want 0", level); end
    tests_run++; if (overflow !== 1'b0 || full !== 1'b0) begin tests_failed++; $display("FAIL rst_flags got ovf=%0d full=%0d want 0 0", overflow, full); end
    rst = 1'b0;
    repeat (10) cyc();
    tests_run++; if (empty !== 1'b1 || out_valid !== 1'b0) begin tests_failed++; $display("FAIL idle_empty got empty=%0d valid=%0d want 1 0", empty, out_valid); end
    tests_run++; if (out_code !== 2'd0) begin tests_failed++; $display("FAIL idle_code got %0d want 0", out_code); end
    tests_run++; if (ev_cnt !== 8'd0) begin tests_failed++; $display("FAIL idle_evcnt got %0d want 0", ev_cnt); end
  endtask

  task automatic test_single_event();
    do_reset();
    v = 1'b1; aout = 2'd2;
    cyc();
    tests_run++; if (out_valid !== 1'b1 || out_code !== 2'd2) begin tests_failed++; $display("FAIL latency got valid=%0d code=%0d want 1 2", out_valid, out_code); end
    repeat (4) cyc();
    v = 1'b0;
    cyc();
    tests_run++; if (level !== 3'd1) begin tests_failed++; $display("FAIL held_level got %0d want 1", level); end
    tests_run++; if (out_code !== 2'd2) begin tests_failed++; $display("FAIL held_code got %0d want 2", out_code); end
    tests_run++; if (ev_cnt !== 8'd1) begin tests_failed++; $display("FAIL held_evcnt got %0d want 1", ev_cnt); end
    pop = 1'b1;
    cyc();
    pop = 1'b0;
    tests_run++; if (empty !== 1'b1 || out_valid !== 1'b0) begin tests_failed++; $display("FAIL pop_last got empty=%0d valid=%0d want 1 0", empty, out_valid); end
  endtask

  task automatic test_overflow();
    logic [1:0] codes [0:4];
    logic [1:0] expq [0:3];
    codes = '{2'd1, 2'd3, 2'd0, 2'd2, 2'd1};
    expq  = '{2'd1, 2'd3, 2'd0, 2'd2};
    do_reset();
    v = 1'b1;
    for (int i = 0; i < 4; i++) begin
      aout = codes[i];
      cyc();
    end
    tests_run++; if (full !== 1'b1 || level !== 3'd4) begin tests_failed++; $display("FAIL fill got full=%0d level=%0d want 1 4", full, level); end
    tests_run++; if (overflow !== 1'b0) begin tests_failed++; $display("FAIL fill_ovf got %0d want 0", overflow); end
    aout = codes[4];
    cyc();
    v = 1'b0;
    tests_run++; if (overflow !== 1'b1) begin tests_failed++; $display("FAIL drop_ovf got %0d want 1", overflow); end
    tests_run++; if (ev_cnt !== 8'd4 || level !== 3'd4) begin tests_failed++; $display("FAIL drop_cnt got evcnt=%0d level=%0d want 4 4", ev_cnt, level); end
    for (int i = 0; i < 4; i++) begin
      tests_run++; if (out_code !== expq[i]) begin tests_failed++; $display("FAIL drain_%0d got %0d want %0d", i, out_code, expq[i]); end
      pop = 1'b1;
      cyc();
    end
    pop = 1'b0;
    tests_run++; if (empty !== 1'b1 || overflow !== 1'b1) begin tests_failed++; $display("FAIL drained got empty=%0d ovf=%0d want 1 1", empty, overflow); end
  endtask

  task automatic test_full_push_pop();
    logic [1:0] expq [0:3];
    expq = '{2'd1, 2'd2, 2'd3, 2'd0};
    do_reset();
    v = 1'b1;
    for (int i = 0; i < 4; i++) begin
      aout = 2'(i);
      cyc();
    end
    aout = 2'd0; pop = 1'b1;
    cyc();
    v = 1'b0;
    tests_run++; if (level !== 3'd4 || full !== 1'b1) begin tests_failed++; $display("FAIL pp_level got level=%0d full=%0d want 4 1", level, full); end
    tests_run++; if (overflow !== 1'b0) begin tests_failed++; $display("FAIL pp_ovf got %0d want 0", overflow); end
    tests_run++; if (ev_cnt !== 8'd5) begin tests_failed++; $display("FAIL pp_evcnt got %0d want 5", ev_cnt); end
    for (int i = 0; i < 4; i++) begin
      tests_run++; if (out_code !== expq[i]) begin tests_failed++; $display("FAIL pp_drain_%0d got %0d want %0d", i, out_code, expq[i]); end
      cyc();
    end
    pop = 1'b0;
    tests_run++; if (empty !== 1'b1) begin tests_failed++; $display("FAIL pp_empty got %0d want 1", empty); end
  endtask

  task automatic test_back_to_back();
    logic [1:0] seq [0:8];
    seq = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1, 2'd2, 2'd3, 2'd1};
    do_reset();
    pop = 1'b1; v = 1'b0;
    repeat (3) cyc();
    tests_run++; if (level !== 3'd0 || empty !== 1'b1 || overflow !== 1'b0) begin tests_failed++; $display("FAIL pop_empty got level=%0d empty=%0d ovf=%0d want 0 1 0", level, empty, overflow); end
    v = 1'b1;
    for (int i = 0; i < 9; i++) begin
      aout = seq[i];
      cyc();
      tests_run++; if (out_code !== seq[i] || level !== 3'd1) begin tests_failed++; $display("FAIL wrap_%0d got code=%0d level=%0d want %0d 1", i, out_code, level, seq[i]); end
    end
    v = 1'b0;
    cyc();
    pop = 1'b0;
    tests_run++; if (empty !== 1'b1 || ev_cnt !== 8'd9) begin tests_failed++; $display("FAIL wrap_end got empty=%0d evcnt=%0d want 1 9", empty, ev_cnt); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    v = 1'b1;
    for (int i = 1; i < 4; i++) begin
      aout = 2'(i);
      cyc();
    end
    tests_run++; if (level !== 3'd3) begin tests_failed++; $display("FAIL mid_load got %0d want 3", level); end
    rst = 1'b1; aout = 2'd1;
    cyc();
    tests_run++; if (level !== 3'd0 || empty !== 1'b1 || out_valid !== 1'b0 || out_code !== 2'd0) begin tests_failed++; $display("FAIL mid_rst got level=%0d empty=%0d valid=%0d code=%0d want 0 1 0 0", level, empty, out_valid, out_code); end
    tests_run++; if (full !== 1'b0 || overflow !== 1'b0 || ev_cnt !== 8'd0) begin tests_failed++; $display("FAIL mid_rst_flags got full=%0d ovf=%0d evcnt=%0d want 0 0 0", full, overflow, ev_cnt); end
    rst = 1'b0;
    cyc();
    tests_run++; if (level !== 3'd1 || out_code !== 2'd1 || ev_cnt !== 8'd1) begin tests_failed++; $display("FAIL mid_release got level=%0d code=%0d evcnt=%0d want 1 1 1", level, out_code, ev_cnt); end
    cyc();
    tests_run++; if (level !== 3'd1) begin tests_failed++; $display("FAIL mid_hold got %0d want 1", level); end
    v = 1'b0;
  endtask

  task automatic test_saturate();
    logic [1:0] seq [0:4];
    seq = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    do_reset();
    v = 1'b1; pop = 1'b1;
    for (int i = 0; i < 5; i++) begin
      aout = seq[i];
      cyc();
    end
    v = 1'b0; pop = 1'b0;
    tests_run++; if (s_ev_cnt !== 2'd3) begin tests_failed++; $display("FAIL sat_small got %0d want 3", s_ev_cnt); end
    tests_run++; if (ev_cnt !== 8'd5) begin tests_failed++; $display("FAIL sat_wide got %0d want 5", ev_cnt); end
    tests_run++; if (s_overflow !== 1'b0 || s_level !== 3'd1) begin tests_failed++; $display("FAIL sat_state got ovf=%0d level=%0d want 0 1", s_overflow, s_level); end
  endtask

  initial begin
    test_reset();
    test_single_event();
    test_overflow();
    test_full_push_pop();
    test_back_to_back();
    test_reset_mid();
    test_saturate();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/lab2_encoder_event_fifo.md
# lab2_encoder_event_fifo

Downstream stage for the 4-bit priority encoder. It watches the encoder's `{V, Aout}` outputs every clock and detects each new encoded event. Each event's 2-bit code is pushed into a small first-word-fall-through FIFO, which a consumer drains with a pop strobe. It also keeps an accepted-event counter and a sticky overflow flag.

## Interface
- `DEPTH`, default 4: FIFO entries. Power of two, 2..16.
- `CNT_W`, default 8: width of the accepted-event counter.
- `clk`  in  1: single clock; all state updates on rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `aout`  in  2: encoded index from the priority encoder (`D[0]` highest priority → code 0).
- `v`  in  1: encoder valid; at least one request line active.
- `pop`  in  1: consumer takes the head entry this cycle.
- `out_code`  out  2: head entry. Forced to 0 when empty.
- `out_valid`  out  1: FIFO non-empty.
- `level`  out  $clog2(DEPTH)+1: number of stored entries.
- `full`  out  1: `level == DEPTH`.
- `empty`  out  1: `level == 0`.
- `overflow`  out  1: sticky; an event was dropped because the FIFO was full.
- `ev_cnt`  out  CNT_W: accepted (pushed) events. Saturates at 2^CNT_W−1.

## Operation
- History registers `prev_v` and `prev_aout` load `v` and `aout` every non-reset cycle.
- Event condition, combinational: `v && (!prev_v || aout != prev_aout)`.
  - A held code produces exactly one event.
  - A code change while `v` stays high is a new event.
  - `v` low produces nothing, whatever `aout` holds.
- Push request equals the event condition. Pop request is `pop && out_valid`; pop while empty is ignored with no state change.
- FIFO storage:
  - Circular buffer; read and write pointers of width $clog2(DEPTH).
  - Pointers wrap from DEPTH−1 to 0.
  - `level` is tracked separately.
- Push/pop outcomes:
  - Push only, not full: write `aout` at the write pointer, advance it, `level+1`, `ev_cnt+1` (saturating).
  - Push only, full: entry is dropped; `overflow` ← 1; `level`, `ev_cnt` and pointers are unchanged.
  - Push and pop in the same cycle, any level including full: both are performed and `level` is unchanged. The push is accepted, so no overflow and `ev_cnt+1`.
  - Pop only: advance the read pointer, `level−1`.
- `overflow` is cleared only by `rst`.
- `ev_cnt` holds at its maximum once saturated.
- Outputs `out_code`, `out_valid`, `full`, `empty` and `level` are derived from registered state only; there is no combinational path from `aout`/`v`/`pop`.

## Timing
- Reset values, applied on the first rising edge with `rst=1`:
  - `prev_v=0`, `prev_aout=0`, pointers 0.
  - `level=0`, `out_code=0`, `out_valid=0`, `full=0`, `empty=1`, `overflow=0`, `ev_cnt=0`.
- Reset mid-operation:
  - Stored entries are discarded.
  - Input events during `rst` cycles are not recorded.
  - Because `prev_v` is cleared, a `v=1` held across reset release produces one event on the first cycle with `rst=0`.
- Latency: an event sampled at edge N is visible on `out_code`/`out_valid` after edge N, i.e. in cycle N+1, provided the FIFO was empty.
- Pop: `out_code` shows the next entry in the cycle after the popping edge. `out_valid` falls in that cycle if the last entry was popped.
- Throughput: one push and one pop per cycle.

## Test plan
- Reset, then hold `v=0`, `aout=3` for 10 cycles → `empty=1`, `out_valid=0`, `out_code=0`, `ev_cnt=0`.
- Hold `v=1`, `aout=2` for 5 cycles, then `v=0` → exactly one entry, code 2, `level=1`, `ev_cnt=1`. Pop → `empty=1` next cycle.
- Drive one event each of codes 1, 3, 0, 2, 1 with `v=1` and a changing `aout`, no pop, `DEPTH=4`:
  - `full=1` after the 4th; the 5th is dropped, `overflow=1`, `ev_cnt=4`.
  - Pops return 1, 3, 0, 2 in order.
- With the FIFO full, a new event plus `pop=1` in the same cycle → head removed, new code appended, `level` stays 4, `overflow` stays 0, `ev_cnt+1`.
- `pop=1` while empty for 3 cycles → no change; `level=0`, pointers unchanged, and a later push/pop works normally across pointer wrap after 2×DEPTH cycles of traffic.
- Load 3 entries, assert `rst` for 1 cycle with `v=1`, `aout=1` held → during reset all outputs are at their reset values. The first cycle after release pushes code 1, `ev_cnt=1`. With `CNT_W=2`, five accepted events → `ev_cnt` saturates at 3.
